// File: rtl/uart_pkg.sv
// uart_pkg: shared launch-FSM state type and default UART TX FIFO constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_DATA_W = 8;
  localparam int BUSY_TIMEOUT = 4;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: storage array with wrapping read/write pointers; head is read combinationally
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: TX byte queue with launch FSM handshaking to a busy-reporting transmitter
// Optional UART_TX_FIFO_THRESH_EN adds thresh input and registered thresh_irq (level<=thresh).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   flush,
  input  logic                   ovf_clr,
  input  logic                   go,
  input  logic                   tx_busy,
  output logic                   tx_en,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef UART_TX_FIFO_THRESH_EN
  ,
  input  logic [$clog2(DEPTH):0] thresh,
  output logic                   thresh_irq
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(BUSY_TIMEOUT);
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] head;
  logic push, pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign push = wr_en && !full && !flush;
  assign pop = state == LAUNCH && !empty;
  uart_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .push(push),
    .pop(pop),
    .wr_data(wr_data),
    .head(head)
  );
  always_ff @(posedge clk)
    if (rst) begin
      level <= '0;
      overflow <= 1'b0;
    end else begin
      level <= flush ? '0 : level + LW'(push) - LW'(pop);
      overflow <= (wr_en && full && !flush) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
  // tx_data is captured on entry to LAUNCH so a same-cycle flush cannot disturb it
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tx_en <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        IDLE:
          if (go && !empty && !tx_busy) begin
            state <= LAUNCH;
            tx_en <= 1'b1;
            tx_data <= head;
          end
        LAUNCH: begin
          state <= WAIT_BUSY;
          cnt <= '0;
        end
        WAIT_BUSY:
          if (tx_busy) state <= WAIT_DONE;
          else if (cnt == CW'(BUSY_TIMEOUT - 1)) state <= IDLE;
          else cnt <= cnt + 1'b1;
        WAIT_DONE:
          if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef UART_TX_FIFO_THRESH_EN
  always_ff @(posedge clk)
    thresh_irq <= rst ? 1'b0 : level <= thresh;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench with a transmitter busy model and tx_en monitor
module tb_uart_tx_fifo;
  logic clk = 0, rst = 1, wr_en = 0, flush = 0, ovf_clr = 0, go = 0;
  logic [7:0] wr_data = 0;
  logic tx_busy, tx_en, full, empty, overflow;
  logic [7:0] tx_data;
  logic [4:0] level;
  logic model_on = 0, man_busy = 0, model_busy = 0, start = 0;
  logic [4:0] thresh = 5'd2;
  logic thresh_irq;
  int checks = 0, errors = 0;
  int busy_cnt = 0, cyc = 0, last_cyc = 0, gap = 0, n_tx = 0;
  int n0, n1, n2;
  logic [7:0] tx_log [256];
  assign tx_busy = model_on ? model_busy : man_busy;
  always #5 clk = ~clk;
  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .ovf_clr(ovf_clr), .go(go), .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
`ifdef UART_TX_FIFO_THRESH_EN
    , .thresh(thresh), .thresh_irq(thresh_irq)
`endif
  );
`ifndef UART_TX_FIFO_THRESH_EN
  assign thresh_irq = 1'b0;
`endif
  // transmitter model raises busy the cycle after tx_en, for 10 cycles; also logs launches
  always @(posedge clk) begin
    #1;
    cyc++;
    if (busy_cnt > 0) busy_cnt--;
    if (start) busy_cnt = 10;
    start = tx_en;
    model_busy = busy_cnt > 0;
    if (tx_en) begin
      tx_log[n_tx % 256] = tx_data;
      gap = cyc - last_cyc;
      last_cyc = cyc;
      n_tx++;
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    wr_en = 1;
    wr_data = d;
    tick;
    wr_en = 0;
  endtask
  task automatic wait_ntx(input int target, input int lim, input string tag);
    for (int i = 0; i < lim && n_tx < target; i++) tick;
    chk(tag, 32'(n_tx >= target), 1);
  endtask
  task automatic wait_busy(input int lim, input string tag);
    for (int i = 0; i < lim && !tx_busy; i++) tick;
    chk(tag, 32'(tx_busy), 1);
  endtask
  initial begin
    tick;
    tick;
    rst = 0;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    model_on = 1;
    go = 1;
    push(8'hA5);
    push(8'h3C);
    wait_ntx(2, 100, "two_launch_timeout");
    tick;
    chk("first_byte", tx_log[0], 8'hA5);
    chk("second_byte", tx_log[1], 8'h3C);
    chk("gap_ge_13", 32'(gap >= 13), 1);
    chk("drained_empty", empty, 1);
    for (int i = 0; i < 20; i++) tick;
    model_on = 0;
    go = 0;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    chk("full_16", full, 1);
    chk("level_16", level, 16);
    chk("no_ovf_yet", overflow, 0);
    push(8'hEE);
    chk("ovf_set", overflow, 1);
    chk("level_held", level, 16);
    ovf_clr = 1;
    tick;
    ovf_clr = 0;
    chk("ovf_clr", overflow, 0);
    n0 = n_tx;
    go = 1;
    tick;
    chk("launch_strobe", tx_en, 1);
    chk("launch_data", tx_data, 8'h10);
    wr_en = 1;
    wr_data = 8'h77;
    go = 0;
    tick;
    wr_en = 0;
    chk("pushpop_level", level, 15);
    chk("pushpop_ovf", overflow, 1);
    chk("strobe_one_cycle", tx_en, 0);
    ovf_clr = 1;
    go = 1;
    tick;
    ovf_clr = 0;
    wait_ntx(n0 + 3, 40, "timeout_launch");
    chk("timeout_byte1", tx_log[n0 + 1], 8'h11);
    chk("timeout_byte2", tx_log[n0 + 2], 8'h12);
    chk("timeout_gap", gap, 6);
    wait_ntx(n0 + 16, 200, "drain_timeout");
    chk("last_byte", tx_log[n0 + 15], 8'h1F);
    for (int i = 0; i < 8; i++) tick;
    chk("drain_empty", empty, 1);
    chk("no_17th_launch", n_tx, n0 + 16);
    go = 0;
    model_on = 1;
    for (int i = 0; i < 6; i++) push(8'(8'h51 + i));
    go = 1;
    wait_busy(20, "busy_wait");
    tick;
    chk("wait_done_level", level, 5);
    flush = 1;
    tick;
    flush = 0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    n1 = n_tx;
    for (int i = 0; i < 30; i++) tick;
    chk("flush_no_tx", n_tx, n1);
    push(8'h61);
    push(8'h62);
    wait_busy(20, "busy_wait2");
    rst = 1;
    tick;
    rst = 0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    n2 = n_tx;
    for (int i = 0; i < 30; i++) tick;
    chk("mid_rst_no_tx", n_tx, n2);
`ifdef UART_TX_FIFO_THRESH_EN
    model_on = 0;
    man_busy = 0;
    go = 0;
    push(8'h71);
    push(8'h72);
    push(8'h73);
    tick;
    chk("thr_lvl3_irq", thresh_irq, 0);
    go = 1;
    n0 = n_tx;
    wait_ntx(n0 + 1, 20, "thr_launch");
    go = 0;
    chk("thr_launch_level", level, 3);
    tick;
    chk("thr_level2", level, 2);
    chk("thr_irq_lag", thresh_irq, 0);
    tick;
    chk("thr_irq_rise", thresh_irq, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
